// File: rtl/median_pkg.sv
// Shared types and constants for the median filter front end.
package median_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} feeder_state_t;

  localparam int unsigned WIN_SIZE = 9;

endpackage

// File: rtl/line_buffer.sv
// Enabled shift register. Q is the sample pushed DEPTH enables ago, i.e. the
// same column one image line earlier when DEPTH equals the line length.
module line_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             CLK,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (EN) begin
      sr_q[0] <= D;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign Q = sr_q[DEPTH-1];

endmodule

// File: rtl/median_window_feeder.sv
// Builds a 3x3 window over a raster pixel stream and serialises each interior
// window into the MEDIAN core, returning one filtered pixel per window.
module median_window_feeder
  import median_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_RDY,
  output logic [WIDTH-1:0] MED_DI,
  output logic             MED_DSI,
  input  logic [WIDTH-1:0] MED_DO,
  input  logic             MED_DSO,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  output logic             OUT_LAST
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam logic [ColW-1:0] ColMax = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(IMG_H - 1);
  localparam logic [3:0]      KLast  = 4'(WIN_SIZE - 1);

  feeder_state_t    state_q, state_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [3:0]       k_q, k_d;
  logic             last_pend_q, last_pend_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic [WIDTH-1:0] win_q [3][3];
  logic [WIDTH-1:0] lb0_out, lb1_out;
  logic             accept, win_ok, frame_last;

  assign IN_RDY     = (state_q == IDLE);
  assign accept     = IN_VALID & IN_RDY;
  assign win_ok     = (row_q >= RowW'(2)) && (col_q >= ColW'(2));
  assign frame_last = (row_q == RowMax) && (col_q == ColMax);

  line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb0 (
    .CLK (CLK),
    .EN  (accept),
    .D   (IN_DATA),
    .Q   (lb0_out)
  );

  line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb1 (
    .CLK (CLK),
    .EN  (accept),
    .D   (lb0_out),
    .Q   (lb1_out)
  );

  // Window is only ever read once the counters say it is fully populated.
  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb1_out;
      win_q[1][2] <= lb0_out;
      win_q[2][2] <= IN_DATA;
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == ColMax) begin
        col_d = '0;
        row_d = (row_q == RowMax) ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    last_pend_d = last_pend_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && win_ok) begin
          state_d     = SEND;
          k_d         = '0;
          last_pend_d = frame_last;
        end
      end
      SEND: begin
        if (k_q == KLast) begin
          state_d = WAIT;
          k_d     = '0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      WAIT: begin
        if (MED_DSO) begin
          out_data_d  = MED_DO;
          out_valid_d = 1'b1;
          out_last_d  = last_pend_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      k_q         <= '0;
      last_pend_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      k_q         <= k_d;
      last_pend_q <= last_pend_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Row-major serialisation, top-left first.
  always_comb begin
    MED_DI = '0;
    if (state_q == SEND) begin
      case (k_q)
        4'd0:    MED_DI = win_q[0][0];
        4'd1:    MED_DI = win_q[0][1];
        4'd2:    MED_DI = win_q[0][2];
        4'd3:    MED_DI = win_q[1][0];
        4'd4:    MED_DI = win_q[1][1];
        4'd5:    MED_DI = win_q[1][2];
        4'd6:    MED_DI = win_q[2][0];
        4'd7:    MED_DI = win_q[2][1];
        4'd8:    MED_DI = win_q[2][2];
        default: MED_DI = '0;
      endcase
    end
  end

  assign MED_DSI   = (state_q == SEND);
  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Directed bench: three feeder instances (3x3, 5x5, 4x3) each paired with a
// behavioural MEDIAN core model answering 46 cycles after each burst.
module tb_median_window_feeder;

  localparam int NI  = 3;
  localparam int LAT = 46;

  typedef struct {
    int         g;
    logic [7:0] d;
    logic       l;
  } out_t;

  logic       CLK;
  logic       nRST;
  logic [7:0] in_data   [NI];
  logic       in_valid  [NI];
  logic       in_rdy    [NI];
  logic [7:0] med_di    [NI];
  logic       med_dsi   [NI];
  logic [7:0] med_do    [NI];
  logic       med_dso   [NI];
  logic [7:0] out_data  [NI];
  logic       out_valid [NI];
  logic       out_last  [NI];

  int rdy_viol [NI];
  int dso_viol [NI];
  int bad_run  [NI];
  int bursts   [NI];

  out_t       outs   [$];
  logic [7:0] di_log [$];
  logic [7:0] pix    [$];

  int n_assert = 0;
  int n_fail   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] med9(input logic [71:0] v);
    logic [7:0] a [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) a[i] = v[i*8 +: 8];
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
      end
    end
    return a[4];
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    median_window_feeder #(
      .WIDTH (8),
      .IMG_W (g == 0 ? 3 : (g == 1 ? 5 : 4)),
      .IMG_H (g == 0 ? 3 : (g == 1 ? 5 : 3))
    ) u_dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .IN_DATA   (in_data[g]),
      .IN_VALID  (in_valid[g]),
      .IN_RDY    (in_rdy[g]),
      .MED_DI    (med_di[g]),
      .MED_DSI   (med_dsi[g]),
      .MED_DO    (med_do[g]),
      .MED_DSO   (med_dso[g]),
      .OUT_DATA  (out_data[g]),
      .OUT_VALID (out_valid[g]),
      .OUT_LAST  (out_last[g])
    );

    // MEDIAN core model: collects a DSI burst, answers LAT cycles later.
    initial begin : model
      logic [71:0] wpk;
      logic [7:0]  res;
      int          run;
      int          cd;
      logic        pend;
      run = 0; cd = 0; pend = 1'b0; wpk = '0; res = '0;
      med_dso[g] = 1'b0;
      med_do[g]  = '0;
      rdy_viol[g] = 0; dso_viol[g] = 0; bad_run[g] = 0; bursts[g] = 0;
      forever begin
        @(negedge CLK);
        med_dso[g] = 1'b0;
        if (!nRST) begin
          run = 0; cd = 0; pend = 1'b0;
        end else begin
          if (med_dsi[g]) begin
            if (in_rdy[g]) rdy_viol[g]++;
            if (run < 9) wpk[run*8 +: 8] = med_di[g];
            if (g == 0) di_log.push_back(med_di[g]);
            run++;
          end else if (run != 0) begin
            bursts[g]++;
            if (run != 9) bad_run[g]++;
            res  = med9(wpk);
            cd   = LAT;
            pend = 1'b1;
            run  = 0;
          end
          if (pend) begin
            if (in_rdy[g]) rdy_viol[g]++;
            cd--;
            if (cd == 0) begin
              if (in_rdy[g] || med_dsi[g]) dso_viol[g]++;
              med_dso[g] = 1'b1;
              med_do[g]  = res;
              pend       = 1'b0;
            end
          end
        end
      end
    end

    initial begin : mon
      forever begin
        @(negedge CLK);
        if (out_valid[g]) outs.push_back('{g: g, d: out_data[g], l: out_last[g]});
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Feeds pix[] into instance g; called at a negedge, returns at a negedge.
  task automatic send(input int g, input bit toggle);
    int t;
    int gaps;
    for (int i = 0; i < pix.size(); i++) begin
      gaps = 0;
      while (toggle && ($urandom_range(0, 1) == 1) && gaps < 4) begin
        in_valid[g] = 1'b0;
        in_data[g]  = 8'hEE;
        @(negedge CLK);
        gaps++;
      end
      in_valid[g] = 1'b1;
      in_data[g]  = pix[i];
      t = 0;
      while (!in_rdy[g] && t < 500) begin
        @(negedge CLK);
        t++;
      end
      if (t >= 500) begin
        check("accept_timeout", 32'(t), 32'd0);
        in_valid[g] = 1'b0;
        return;
      end
      @(negedge CLK);
    end
    in_valid[g] = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    int t;
    t = 0;
    while (outs.size() < n && t < 2000) begin
      @(negedge CLK);
      t++;
    end
    repeat (5) @(negedge CLK);
    check("out_count", 32'(outs.size()), 32'(n));
  endtask

  task automatic check_out(input string tag, input int idx, input int g,
                           input logic [7:0] d, input logic l);
    if (idx < outs.size()) begin
      check({tag, "_inst"}, 32'(outs[idx].g), 32'(g));
      check({tag, "_data"}, 32'(outs[idx].d), 32'(d));
      check({tag, "_last"}, 32'(outs[idx].l), 32'(l));
    end else begin
      check({tag, "_missing"}, 32'(outs.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0;
    for (int g = 0; g < NI; g++) begin
      in_valid[g] = 1'b0;
      in_data[g]  = '0;
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    // 1: reset values
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("rst_in_rdy", 32'(in_rdy[0]), 32'd1);
      check("rst_med_dsi", 32'(med_dsi[0]), 32'd0);
      check("rst_out_valid", 32'(out_valid[0]), 32'd0);
      check("rst_out_data", 32'(out_data[0]), 32'd0);
    end
    check("rst_med_di", 32'(med_di[0]), 32'd0);
    check("rst_out_last", 32'(out_last[0]), 32'd0);

    // 2: 3x3 frame 1..9
    outs.delete(); di_log.delete(); pix.delete();
    for (int i = 1; i <= 9; i++) pix.push_back(8'(i));
    send(0, 1'b0);
    wait_outs(1);
    check_out("f3x3", 0, 0, 8'd5, 1'b1);
    check("f3x3_di_count", 32'(di_log.size()), 32'd9);
    for (int i = 0; i < 9 && i < di_log.size(); i++) check("f3x3_di", 32'(di_log[i]), 32'(i + 1));
    check("f3x3_bursts", 32'(bursts[0]), 32'd1);
    check("f3x3_run_len", 32'(bad_run[0]), 32'd0);
    check("f3x3_rdy_low", 32'(rdy_viol[0]), 32'd0);

    // 3: 5x5 all 10 with centre 255
    outs.delete(); pix.delete();
    for (int i = 0; i < 25; i++) pix.push_back(i == 12 ? 8'd255 : 8'd10);
    send(1, 1'b0);
    wait_outs(9);
    for (int i = 0; i < 9; i++) check_out("f5x5", i, 1, 8'd10, (i == 8));
    check("f5x5_bursts", 32'(bursts[1]), 32'd9);
    check("f5x5_rdy_low", 32'(rdy_viol[1]), 32'd0);

    // 4: 4x3 frame with IN_VALID gaps
    outs.delete(); pix.delete();
    pix = '{8'd3, 8'd8, 8'd1, 8'd6, 8'd9, 8'd2, 8'd7, 8'd4, 8'd5, 8'd0, 8'd11, 8'd10};
    send(2, 1'b1);
    wait_outs(2);
    check_out("f4x3_w0", 0, 2, 8'd5, 1'b0);
    check_out("f4x3_w1", 1, 2, 8'd6, 1'b1);
    check("f4x3_rdy_low", 32'(rdy_viol[2]), 32'd0);

    // 5: two 3x3 frames back-to-back
    outs.delete(); pix.delete();
    for (int i = 1; i <= 9; i++) pix.push_back(8'(i));
    for (int i = 0; i < 9; i++) pix.push_back(8'd200);
    send(0, 1'b0);
    wait_outs(2);
    check_out("b2b_a", 0, 0, 8'd5, 1'b1);
    check_out("b2b_b", 1, 0, 8'd200, 1'b1);

    // 6: reset during WAIT drops the pending result
    outs.delete(); pix.delete();
    for (int i = 1; i <= 9; i++) pix.push_back(8'(i));
    send(0, 1'b0);
    repeat (20) @(negedge CLK);
    check("midwait_rdy", 32'(in_rdy[0]), 32'd0);
    nRST = 1'b0;
    @(negedge CLK);
    check("midrst_rdy", 32'(in_rdy[0]), 32'd1);
    check("midrst_dsi", 32'(med_dsi[0]), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (80) @(negedge CLK);
    check("dropped_out", 32'(outs.size()), 32'd0);
    pix.delete();
    for (int i = 0; i < 9; i++) pix.push_back(8'd7);
    send(0, 1'b0);
    wait_outs(1);
    check_out("after_rst", 0, 0, 8'd7, 1'b1);

    for (int g = 0; g < NI; g++) check("dso_protocol", 32'(dso_viol[g]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
